// File: rtl/alu_param.sv
// alu_param: multi-cycle ALU (add/sub, radix-2 Booth multiply, non-restoring divide) with serial I/O.
// Define ALU_DIV_EN to build the divider; without it op_code 11 returns a zero word with err set.
module alu_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             END,
    output logic             busy,
    output logic [1:0]       flags,
    output logic [2:0]       o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_LOAD_Y, S_EXEC, S_OUT_1, S_OUT_2} state_t;

    state_t           r_state, w_state;
    logic [1:0]       r_op, w_op;
    logic [WIDTH-1:0] r_x, w_x, r_m, w_m, r_q, w_q, r_out, w_out;
    logic [WIDTH:0]   r_a, w_a;
    logic             r_q1, w_q1, r_end, w_end, r_busy, w_busy;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [1:0]       r_flags, w_flags;

    logic [WIDTH-1:0] w_addsub;
    logic             w_ovf;
    logic [WIDTH:0]   w_m_sext, w_booth;

    // A carries one guard bit so Booth partial sums never wrap (e.g. M = most negative value).
    always_comb begin
        w_addsub = (r_op == OP_SUB) ? r_x - r_m : r_x + r_m;
        if (r_op == OP_SUB)
            w_ovf = (r_x[WIDTH-1] != r_m[WIDTH-1]) && (w_addsub[WIDTH-1] != r_x[WIDTH-1]);
        else
            w_ovf = (r_x[WIDTH-1] == r_m[WIDTH-1]) && (w_addsub[WIDTH-1] != r_x[WIDTH-1]);
        w_m_sext = {r_m[WIDTH-1], r_m};
        case ({r_q[0], r_q1})
            2'b01:   w_booth = r_a + w_m_sext;
            2'b10:   w_booth = r_a - w_m_sext;
            default: w_booth = r_a;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0] w_m_zext, w_div_sh, w_div_a, w_div_fix;
    always_comb begin
        w_m_zext  = {1'b0, r_m};
        w_div_sh  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
        w_div_a   = r_a[WIDTH] ? w_div_sh + w_m_zext : w_div_sh - w_m_zext;
        w_div_fix = r_a[WIDTH] ? r_a + w_m_zext : r_a;
    end
`endif

    // Outputs are computed for the state being entered, so outbus/END/flags/busy come straight from flops.
    always_comb begin
        w_state = r_state;
        w_op    = r_op;
        w_x     = r_x;
        w_m     = r_m;
        w_a     = r_a;
        w_q     = r_q;
        w_q1    = r_q1;
        w_cnt   = r_cnt;
        w_busy  = r_busy;
        w_out   = '0;
        w_end   = 1'b0;
        w_flags = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (BEGIN) begin
                    w_op    = op_code;
                    w_busy  = 1'b1;
                    w_state = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                w_x     = inbus;
                w_state = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                w_m     = inbus;
                w_a     = '0;
                w_q     = r_x;
                w_q1    = 1'b0;
                w_cnt   = '0;
                w_state = S_EXEC;
`ifndef ALU_DIV_EN
                if (r_op == OP_DIV) begin
                    w_end   = 1'b1;
                    w_flags = 2'b10;
                    w_state = S_OUT_1;
                end
`endif
            end
            S_EXEC: begin
                if (r_op == OP_MUL) begin
                    w_a   = {w_booth[WIDTH], w_booth[WIDTH:1]};
                    w_q   = {w_booth[0], r_q[WIDTH-1:1]};
                    w_q1  = r_q[0];
                    w_cnt = r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_out   = w_booth[WIDTH:1];
                        w_state = S_OUT_1;
                    end
`ifdef ALU_DIV_EN
                end else if (r_op == OP_DIV) begin
                    if (r_m == '0) begin
                        w_q     = '1;
                        w_a     = {1'b0, r_x};
                        w_out   = '1;
                        w_state = S_OUT_1;
                    end else if (r_cnt == CW'(WIDTH)) begin
                        w_a     = w_div_fix;
                        w_out   = r_q;
                        w_state = S_OUT_1;
                    end else begin
                        w_a   = w_div_a;
                        w_q   = {r_q[WIDTH-2:0], ~w_div_a[WIDTH]};
                        w_cnt = r_cnt + 1'b1;
                    end
`endif
                end else if (r_op != OP_DIV) begin
                    w_out   = w_addsub;
                    w_end   = 1'b1;
                    w_flags = {1'b0, w_ovf};
                    w_state = S_OUT_1;
                end else begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            S_OUT_1: begin
                if (r_end) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_out   = (r_op == OP_MUL) ? r_q : r_a[WIDTH-1:0];
                    w_end   = 1'b1;
                    w_flags = (r_op == OP_DIV && r_m == '0) ? 2'b10 : 2'b00;
                    w_state = S_OUT_2;
                end
            end
            S_OUT_2: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_x     <= '0;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
            r_flags <= 2'b00;
        end else begin
            r_state <= w_state;
            r_op    <= w_op;
            r_x     <= w_x;
            r_m     <= w_m;
            r_a     <= w_a;
            r_q     <= w_q;
            r_q1    <= w_q1;
            r_cnt   <= w_cnt;
            r_out   <= w_out;
            r_end   <= w_end;
            r_busy  <= w_busy;
            r_flags <= w_flags;
        end
    end

    assign outbus      = r_out;
    assign END         = r_end;
    assign busy        = r_busy;
    assign flags       = r_flags;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param: WIDTH=8 and WIDTH=16 instances, vector tables, random ops, mid-operation reset.
module tb_alu_param;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        int          end_c;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [1:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        b8 = 1'b0, b16 = 1'b0;
    logic [1:0]  op8 = 2'b00, op16 = 2'b00;
    logic [7:0]  in8 = '0;
    logic [15:0] in16 = '0;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic        end8, end16, busy8, busy16;
    logic [1:0]  fl8, fl16;
    logic [2:0]  dbg8, dbg16;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    alu_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .BEGIN(b8), .op_code(op8), .inbus(in8),
        .outbus(out8), .END(end8), .busy(busy8), .flags(fl8), .o_dbg_state(dbg8)
    );

    alu_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .BEGIN(b16), .op_code(op16), .inbus(in16),
        .outbus(out16), .END(end16), .busy(busy16), .flags(fl16), .o_dbg_state(dbg16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic vec_t model(input int w, input logic [1:0] op, input logic [31:0] x,
                                   input logic [31:0] y);
        vec_t   v;
        longint mask, lim, ux, uy, sx, sy, s, p;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ux = longint'(x) & mask;
        uy = longint'(y) & mask;
        sx = (ux >= lim) ? ux - (mask + 1) : ux;
        sy = (uy >= lim) ? uy - (mask + 1) : uy;
        v.op = op; v.x = 32'(ux); v.y = 32'(uy); v.w1 = '0; v.fl = 2'b00;
        case (op)
            2'b00, 2'b01: begin
                s = (op == 2'b00) ? sx + sy : sx - sy;
                v.w2 = 32'(s & mask);
                v.fl = {1'b0, (s >= lim) || (s < -lim)};
                v.end_c = 4;
            end
            2'b10: begin
                p = sx * sy;
                v.w1 = 32'((p >>> w) & mask);
                v.w2 = 32'(p & mask);
                v.end_c = 4 + w;
            end
            default: begin
`ifdef ALU_DIV_EN
                if (uy == 0) begin
                    v.w1 = 32'(mask); v.w2 = 32'(ux); v.fl = 2'b10; v.end_c = 5;
                end else begin
                    v.w1 = 32'(ux / uy); v.w2 = 32'(ux % uy); v.end_c = 5 + w;
                end
`else
                v.w2 = '0; v.fl = 2'b10; v.end_c = 3;
`endif
            end
        endcase
        return v;
    endfunction

    task automatic drive(input int w, input logic b, input logic [1:0] op, input logic [31:0] d);
        if (w == 16) begin
            b16 = b; op16 = op; in16 = d[15:0];
        end else begin
            b8 = b; op8 = op; in8 = d[7:0];
        end
    endtask

    task automatic probe(input int w, output logic [31:0] o, output logic e, output logic b,
                         output logic [1:0] f);
        if (w == 16) begin
            o = 32'(out16); e = end16; b = busy16; f = fl16;
        end else begin
            o = 32'(out8); e = end8; b = busy8; f = fl8;
        end
    endtask

    // Called just after a negedge; that cycle is c0. Returns at the negedge of the idle cycle after END.
    task automatic run_op(input int w, input vec_t v);
        int          end_c;
        logic [31:0] prev, last, o;
        logic        e, b, busy_ok;
        logic [1:0]  f, fl;
        exp_q.push_back(v.w1);
        exp_q.push_back(v.w2);
        drive(w, 1'b1, v.op, $urandom);
        @(negedge clk);
        probe(w, o, e, b, f);
        busy_ok = b;
        drive(w, 1'b0, 2'($urandom), v.x);
        @(negedge clk);
        probe(w, o, e, b, f);
        busy_ok &= b;
        drive(w, 1'b0, 2'($urandom), v.y);
        end_c = -1; prev = '0; last = '0; fl = 2'b00;
        for (int k = 3; k < 64 && end_c < 0; k++) begin
            @(negedge clk);
            probe(w, o, e, b, f);
            busy_ok &= b;
            drive(w, 1'b0, 2'($urandom), $urandom);
            if (e) begin
                end_c = k; last = o; fl = f;
            end else begin
                prev = o;
            end
        end
        check($sformatf("end_cycle w%0d op%0d", w, v.op), end_c, v.end_c);
        check($sformatf("word1 w%0d op%0d", w, v.op), prev, exp_q.pop_front());
        check($sformatf("word2 w%0d op%0d", w, v.op), last, exp_q.pop_front());
        check($sformatf("flags w%0d op%0d", w, v.op), fl, v.fl);
        check("busy_during", busy_ok, 1);
        drive(w, 1'b0, 2'b00, '0);
        @(negedge clk);
        probe(w, o, e, b, f);
        check("busy_after", b, 0);
        check("idle_outbus", o, 0);
    endtask

    // Multiply -7*3 on the 8-bit unit, pulling reset low in cycle at_c.
    task automatic mul_reset(input int at_c, input logic [7:0] exp_word);
        int n_end;
        drive(8, 1'b1, 2'b10, '0);
        @(negedge clk);
        drive(8, 1'b0, 2'b00, 32'h0000_00F9);
        @(negedge clk);
        drive(8, 1'b0, 2'b00, 32'h0000_0003);
        for (int k = 3; k <= at_c; k++) @(negedge clk);
        check("pre_reset_busy", busy8, 1);
        check("pre_reset_outbus", out8, exp_word);
        reset = 1'b0;
        #1;
        check("rst_outbus", out8, 0);
        check("rst_end", end8, 0);
        check("rst_busy", busy8, 0);
        check("rst_state", dbg8, 0);
        @(negedge clk);
        reset = 1'b1;
        n_end = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (end8 || busy8) n_end++;
        end
        check("no_partial_result", n_end, 0);
    endtask

    vec_t tbl8[$];
    vec_t tbl16[$];

    initial begin
        tbl8.push_back('{2'b00, 32'd56,   32'd89,   4,  32'h00, 32'h91, 2'b01});
        tbl8.push_back('{2'b01, 32'd56,   32'd89,   4,  32'h00, 32'hDF, 2'b00});
        tbl8.push_back('{2'b01, 32'h80,   32'h01,   4,  32'h00, 32'h7F, 2'b01});
        tbl8.push_back('{2'b10, 32'd7,    32'd3,    12, 32'h00, 32'h15, 2'b00});
        tbl8.push_back('{2'b10, 32'hF9,   32'h03,   12, 32'hFF, 32'hEB, 2'b00});
        tbl8.push_back('{2'b10, 32'h80,   32'h80,   12, 32'h40, 32'h00, 2'b00});
`ifdef ALU_DIV_EN
        tbl8.push_back('{2'b11, 32'd100,  32'd7,    13, 32'd14, 32'd2,  2'b00});
        tbl8.push_back('{2'b11, 32'd100,  32'd0,    5,  32'hFF, 32'd100, 2'b10});
`else
        tbl8.push_back('{2'b11, 32'd100,  32'd7,    3,  32'h00, 32'h00, 2'b10});
`endif
        tbl8.push_back('{2'b00, 32'd1,    32'd1,    4,  32'h00, 32'h02, 2'b00});
        tbl16.push_back('{2'b00, 32'd1234, 32'd4321, 4, 32'h0, 32'd5555, 2'b00});
        tbl16.push_back('{2'b00, 32'h7FFF, 32'h0001, 4, 32'h0, 32'h8000, 2'b01});
        tbl16.push_back('{2'b10, 32'd1234, 32'hFFFD, 20, 32'hFFFF, 32'hF18A, 2'b00});

        #1;
        check("reset_outbus8", out8, 0);
        check("reset_end8", end8, 0);
        check("reset_busy8", busy8, 0);
        check("reset_flags8", fl8, 0);
        check("reset_state8", dbg8, 0);
        check("reset_outbus16", out16, 0);
        check("reset_busy16", busy16, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl8[i]) run_op(8, tbl8[i]);
        foreach (tbl16[i]) run_op(16, tbl16[i]);

        mul_reset(6, 8'h00);
        run_op(8, model(8, 2'b00, 32'd1, 32'd1));
        mul_reset(11, 8'hFF);
        run_op(8, model(8, 2'b00, 32'd1, 32'd1));

        for (int i = 0; i < 30; i++) begin
            logic [31:0] y;
            y = (i % 7 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            run_op(8, model(8, 2'($urandom), 32'($urandom_range(0, 255)), y));
        end
        for (int i = 0; i < 10; i++) begin
            run_op(16, model(16, 2'($urandom_range(0, 2)), 32'($urandom_range(0, 65535)),
                             32'($urandom_range(0, 65535))));
        end
`ifdef ALU_DIV_EN
        run_op(16, model(16, 2'b11, 32'd60000, 32'd7));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_param.md
# alu_param

Parametrised multi-cycle integer ALU: next generation of the 8-bit BEGIN/END sequential ALU, with operand width set by a parameter, signed Booth multiply, non-restoring divide, and status flags. Operands arrive serially on a shared `inbus`; results leave serially on `outbus`, one or two words per operation, framed by `END`. It sits behind the same host handshake (`BEGIN`/`op_code`/`inbus`/`outbus`/`END`) and replaces the fixed-width ALU datapath plus control unit.

## Interface
- `WIDTH`, 8, operand/result word width in bits; legal range 4..32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `BEGIN`  in  1  start request, sampled only in IDLE.
- `op_code`  in  2  00 add, 01 sub, 10 mul (signed), 11 div (unsigned); captured with BEGIN.
- `inbus`  in  WIDTH  operand input; first operand X, then operand Y.
- `outbus`  out  WIDTH  result word; zero outside output states.
- `END`  out  1  high for exactly one cycle, concurrent with the last result word.
- `busy`  out  1  high from the cycle after BEGIN is accepted until END cycle inclusive.
- `flags`  out  2  {err, ovf}; valid only while END=1, zero otherwise.

## Operation
- States: IDLE, LOAD_X, LOAD_Y, EXEC, OUT_1, OUT_2. One state per cycle except EXEC.
- IDLE: BEGIN=1 at edge -> latch op_code, go LOAD_X. BEGIN outside IDLE is ignored.
- LOAD_X: latch inbus into X. LOAD_Y: latch inbus into Y (M register). Next EXEC.
- Add/sub: EXEC 1 cycle, R = X ± Y mod 2^WIDTH; ovf = two's-complement signed overflow. -> OUT_1 (R, END=1).
- Mul: Booth radix-2 on A:Q:q(-1), A=0, Q=X, M=Y; WIDTH iterations, one per cycle (add/sub M per Q[0]:q(-1), then arithmetic right shift of A:Q:q(-1)). Result 2·WIDTH signed. OUT_1 = A (high), OUT_2 = Q (low) + END. ovf = 0.
- Div: non-restoring unsigned, A=0, Q=X, M=Y; WIDTH iterations, then one correction cycle (A<0 -> A+=M). OUT_1 = Q (quotient), OUT_2 = A (remainder) + END.
- Div by zero (Y=0): detected in first EXEC cycle, no iterations; quotient = all ones, remainder = X, err=1.
- Iteration counter: log2-ceil(WIDTH+1) bits, cleared in LOAD_Y, terminal count WIDTH-1.
- After END cycle -> IDLE; BEGIN may be asserted in that IDLE cycle (back-to-back).

## Timing
- Reset (async, reset=0): state IDLE, X/Y/A/Q/counter 0, outbus=0, END=0, busy=0, flags=0; takes effect immediately, including mid-operation; no partial result ever emitted.
- Cycle numbering: c0 = cycle where BEGIN sampled. inbus X sampled end of c1, Y end of c2.
- Add/sub: EXEC c3, END at c4. Latency 4 cycles from BEGIN edge.
- Mul: EXEC c3..c(2+WIDTH), OUT_1 c(3+WIDTH), END c(4+WIDTH). WIDTH=8: END at c12.
- Div: EXEC c3..c(3+WIDTH) incl. correction, OUT_1 c(4+WIDTH), END c(5+WIDTH). WIDTH=8: END at c13. Div by zero: OUT_1 c4, END c5.
- outbus, END, flags, busy are registered (driven directly from flops).
- op_code and inbus changes during EXEC/OUT have no effect.

## Configuration
- `ALU_DIV_EN` defined: divider datapath and correction cycle compiled in, behaviour as above.
- Not defined: no divider logic; op_code 11 goes LOAD_X -> LOAD_Y -> OUT_1 with outbus=0, END=1, err=1 (single word, END at c3).

## Test plan
- WIDTH=8, add 56+89 -> outbus 0x91 with END at c4, flags=01 (signed overflow); busy low at c5.
- Sub 56-89 -> 0xDF, flags=00; sub 0x80-1 -> 0x7F, flags=01.
- Mul 7×3 -> 0x00 at c11, 0x15 with END at c12; mul -7×3 (0xF9,0x03) -> 0xFF, 0xEB; mul -128×-128 -> 0x40, 0x00.
- Div 100/7 -> 14 at c12, 2 with END at c13; div 100/0 -> 0xFF at c4, 100 at c5, flags=10.
- reset pulsed low at c6 of a mul -> outbus/END/busy 0 same cycle; new add 1+1 accepted next -> 0x02.
- Without ALU_DIV_EN: op 11 -> outbus 0, END at c3, flags=10; back-to-back add afterward correct. Repeat add/mul at WIDTH=16 (1234×-3 -> 0xFFFF, 0xF18A).
